// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the two-requester ROM fetch arbiter.
package rom_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
        logic    last;
    } tag_t;

endpackage

// File: rtl/rom_rr_picker.sv
// Two-way round-robin picker; the pointer names the requester favoured on a tie.
module rom_rr_picker
    import rom_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        grant_id_o = ptr_q;
        unique case (req_i)
            2'b01:   grant_id_o = 1'b0;
            2'b10:   grant_id_o = 1'b1;
            default: grant_id_o = ptr_q;
        endcase
        grant_o = '0;
        if (enable_i && (req_i != 2'b00)) begin
            grant_o = grant_id_o ? 2'b10 : 2'b01;
        end
    end

    // After any grant, favour the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = ~grant_id_o;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates two burst requesters onto a synchronous-read ROM and returns
// tagged read data aligned with the ROM's one-cycle read latency.
module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [LEN_W-1:0]  LEN0,
    input  logic [LEN_W-1:0]  LEN1,
    output logic              GNT0,
    output logic              GNT1,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic              RLAST0,
    output logic              RLAST1,
    output logic              BUSY,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA
);

    state_e            state_q, state_d;
    req_id_t           owner_q, owner_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    tag_t              tag_q,   tag_d;

    logic [1:0] gnt;
    logic       pick_id;
    logic       window;
    logic       accept;

    // Accepting on the final beat lets the next burst follow with no gap.
    assign window = (state_q == IDLE) || (rem_q == '0);
    assign accept = (gnt != 2'b00);

    rom_rr_picker u_picker (
        .clk_i      (CLK),
        .rst_ni     (RESETn),
        .req_i      ({REQ1, REQ0}),
        .enable_i   (window && RESETn),
        .advance_i  (accept),
        .grant_o    (gnt),
        .grant_id_o (pick_id)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rem_q   <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rem_d   = rem_q;
        addr_d  = addr_q;

        tag_d.valid = (state_q == ISSUE);
        tag_d.owner = owner_q;
        tag_d.last  = (rem_q == '0);

        if (accept) begin
            state_d = ISSUE;
            owner_d = pick_id;
            addr_d  = pick_id ? ADDR1 : ADDR0;
            rem_d   = pick_id ? LEN1 : LEN0;
        end else if (state_q == ISSUE) begin
            if (rem_q != '0) begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - LEN_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        GNT0     = gnt[0];
        GNT1     = gnt[1];
        ROM_ADDR = addr_q;
        RDATA    = ROM_DATA;
        RVALID0  = tag_q.valid && (tag_q.owner == 1'b0);
        RVALID1  = tag_q.valid && (tag_q.owner == 1'b1);
        RLAST0   = RVALID0 && tag_q.last;
        RLAST1   = RVALID1 && tag_q.last;
        BUSY     = (state_q == ISSUE) || tag_q.valid;
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a scoreboard of expected read beats.
module tb_rom_fetch_arbiter;

    logic       CLK;
    logic       RESETn;
    logic       REQ0, REQ1;
    logic [7:0] ADDR0, ADDR1;
    logic [1:0] LEN0, LEN1;
    logic       GNT0, GNT1;
    logic [7:0] RDATA;
    logic       RVALID0, RVALID1, RLAST0, RLAST1, BUSY;
    logic [7:0] ROM_ADDR;
    logic [7:0] rom_q;

    typedef struct packed {
        logic       owner;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t expq[$];
    int    checks_total  = 0;
    int    checks_passed = 0;

    logic       s_g0, s_g1, s_busy, s_rv;
    logic [7:0] s_addr;

    rom_fetch_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(2)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .REQ0     (REQ0),
        .REQ1     (REQ1),
        .ADDR0    (ADDR0),
        .ADDR1    (ADDR1),
        .LEN0     (LEN0),
        .LEN1     (LEN1),
        .GNT0     (GNT0),
        .GNT1     (GNT1),
        .RDATA    (RDATA),
        .RVALID0  (RVALID0),
        .RVALID1  (RVALID1),
        .RLAST0   (RLAST0),
        .RLAST1   (RLAST1),
        .BUSY     (BUSY),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (rom_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return (a * 8'd3) ^ 8'h5A;
    endfunction

    // Synchronous-read ROM with one cycle of latency.
    always @(posedge CLK) rom_q <= rom_fn(ROM_ADDR);

    task automatic chk(input string nm, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push_burst(input logic owner, input logic [7:0] base, input logic [1:0] len);
        beat_t      b;
        logic [7:0] a;
        for (int k = 0; k <= int'(len); k++) begin
            a       = base + 8'(k);
            b.owner = owner;
            b.data  = rom_fn(a);
            b.last  = (k == int'(len));
            expq.push_back(b);
        end
    endtask

    task automatic monitor();
        beat_t b;
        forever begin
            @(negedge CLK);
            chk("protocol", int'((GNT0 & GNT1) | (RLAST0 & ~RVALID0) |
                                 (RLAST1 & ~RVALID1) | (RVALID0 & RVALID1)), 0);
            if (RESETn) begin
                if (GNT0) push_burst(1'b0, ADDR0, LEN0);
                if (GNT1) push_burst(1'b1, ADDR1, LEN1);
                if (RVALID0 || RVALID1) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_rvalid", 1, 0);
                    end else begin
                        b = expq.pop_front();
                        chk("beat_owner", int'(RVALID1), int'(b.owner));
                        chk("beat_data", int'(RDATA), int'(b.data));
                        chk("beat_last", int'(RVALID1 ? RLAST1 : RLAST0), int'(b.last));
                    end
                end
            end
        end
    endtask

    // One clock: snapshot at negedge, then drop any request that was just granted.
    task automatic cyc();
        @(negedge CLK);
        s_g0   = GNT0;
        s_g1   = GNT1;
        s_addr = ROM_ADDR;
        s_busy = BUSY;
        s_rv   = RVALID0 | RVALID1;
        @(posedge CLK);
        #1;
        if (s_g0) REQ0 = 1'b0;
        if (s_g1) REQ1 = 1'b0;
    endtask

    task automatic idle(input int n);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        for (int i = 0; i < n; i++) cyc();
        chk("queue_drained", expq.size(), 0);
    endtask

    task automatic run_tests();
        logic [7:0] wrap_seq [4];
        wrap_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset state, both requests pending from reset
        RESETn = 1'b0;
        REQ0 = 1'b1; ADDR0 = 8'h00; LEN0 = 2'd1;
        REQ1 = 1'b1; ADDR1 = 8'h80; LEN1 = 2'd1;
        #1;
        chk("rst_rom_addr", ROM_ADDR, 0);
        chk("rst_rvalid", int'(RVALID0 | RVALID1), 0);
        chk("rst_rlast", int'(RLAST0 | RLAST1), 0);
        chk("rst_busy", BUSY, 0);
        cyc();
        chk("rst_gnt", int'({s_g1, s_g0}), 0);
        cyc();
        RESETn = 1'b1;

        // Simultaneous requests: 0 first, 1 in the last-beat window, then 0 again
        cyc(); chk("rr_t0_gnt", int'({s_g1, s_g0}), 1);
        cyc(); chk("rr_t1_gnt", int'({s_g1, s_g0}), 0); chk("rr_t1_addr", s_addr, 8'h00);
        cyc(); chk("rr_t2_gnt", int'({s_g1, s_g0}), 2); chk("rr_t2_addr", s_addr, 8'h01);
        REQ0 = 1'b1; ADDR0 = 8'h20; LEN0 = 2'd0;
        REQ1 = 1'b1; ADDR1 = 8'h30; LEN1 = 2'd0;
        cyc(); chk("rr_t3_gnt", int'({s_g1, s_g0}), 0); chk("rr_t3_addr", s_addr, 8'h80);
        cyc(); chk("rr_t4_gnt", int'({s_g1, s_g0}), 1); chk("rr_t4_addr", s_addr, 8'h81);
        cyc(); chk("rr_t5_gnt", int'({s_g1, s_g0}), 2); chk("rr_t5_addr", s_addr, 8'h20);
        cyc(); chk("rr_t6_addr", s_addr, 8'h30);
        idle(4);

        // Single 4-beat burst from requester 0
        REQ0 = 1'b1; ADDR0 = 8'h10; LEN0 = 2'd3;
        cyc(); chk("b0_gnt0", s_g0, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(); chk("b0_addr", s_addr, 8'h10 + k);
        end
        cyc(); chk("b0_busy_t5", s_busy, 1);
        cyc(); chk("b0_busy_t6", s_busy, 0);
        idle(2);

        // Address wrap on requester 1
        REQ1 = 1'b1; ADDR1 = 8'hFE; LEN1 = 2'd3;
        cyc(); chk("wrap_gnt1", s_g1, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(); chk("wrap_addr", s_addr, wrap_seq[k]);
        end
        idle(3);

        // Requester 1 waits until the final-beat cycle of a requester-0 burst
        REQ0 = 1'b1; ADDR0 = 8'h40; LEN0 = 2'd3;
        cyc(); chk("hold_gnt0", s_g0, 1);
        REQ1 = 1'b1; ADDR1 = 8'h50; LEN1 = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(); chk("hold_no_gnt1", s_g1, 0);
        end
        cyc(); chk("hold_gnt1", s_g1, 1); chk("hold_last_addr", s_addr, 8'h43);
        cyc(); chk("hold_next_addr", s_addr, 8'h50);
        idle(4);

        // One-cycle request outside the accept window is withdrawn
        REQ1 = 1'b1; ADDR1 = 8'h60; LEN1 = 2'd3;
        cyc(); chk("wd_gnt1", s_g1, 1);
        REQ0 = 1'b1; ADDR0 = 8'h70; LEN0 = 2'd0;
        cyc(); chk("wd_no_gnt0", s_g0, 0); chk("wd_addr", s_addr, 8'h60);
        REQ0 = 1'b0;
        for (int k = 1; k < 4; k++) begin
            cyc(); chk("wd_no_gnt0", s_g0, 0); chk("wd_addr", s_addr, 8'h60 + k);
        end
        idle(4);

        // Asynchronous reset in the middle of a burst
        REQ0 = 1'b1; ADDR0 = 8'h10; LEN0 = 2'd3;
        cyc(); chk("mr_gnt0", s_g0, 1);
        cyc();
        cyc();
        chk("mr_pre_rvalid", RVALID0, 1);
        RESETn = 1'b0;
        #1;
        chk("mr_rvalid", int'(RVALID0 | RVALID1), 0);
        chk("mr_rlast", int'(RLAST0 | RLAST1), 0);
        chk("mr_busy", BUSY, 0);
        chk("mr_rom_addr", ROM_ADDR, 0);
        expq.delete();
        cyc();
        cyc();
        RESETn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(); chk("mr_no_beats", s_rv, 0);
        end
        REQ0 = 1'b1; ADDR0 = 8'h33; LEN0 = 2'd1;
        cyc(); chk("mr_regnt0", s_g0, 1);
        cyc(); chk("mr_addr0", s_addr, 8'h33);
        cyc(); chk("mr_addr1", s_addr, 8'h34);
        idle(3);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
